// File: rtl/nn_pkg.sv
// Shared types and helpers for the neuron datapath: FSM state encoding,
// default operand widths and a width-generic sign-extension function.
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OUT
    } state_t;

    localparam int W_WIDTH_DEF   = 4;
    localparam int A_WIDTH_DEF   = 8;
    localparam int ACC_WIDTH_DEF = 16;
    localparam int SEXT_MAX      = 64;

    // Replicates bit (w-1) of v into every position at or above w; w must be 1..63.
    function automatic logic [SEXT_MAX-1:0] sext(input logic [SEXT_MAX-1:0] v,
                                                 input logic [5:0]          w);
        logic [SEXT_MAX-1:0] r;
        for (int i = 0; i < SEXT_MAX; i++) begin
            r[i] = (i < int'(w)) ? v[i] : v[w - 6'd1];
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Combinational multiply-accumulate: signed weight times unsigned activation,
// sign-extended to the accumulator width and added to the running sum.
module mac_unit
    import nn_pkg::*;
#(
    parameter int W_WIDTH   = W_WIDTH_DEF,
    parameter int A_WIDTH   = A_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic [ACC_WIDTH-1:0] acc_in,
    input  logic [W_WIDTH-1:0]   weight,
    input  logic [A_WIDTH-1:0]   act,
    output logic [ACC_WIDTH-1:0] acc_out
);

    localparam int PROD_W = W_WIDTH + A_WIDTH + 1;

    logic signed [PROD_W-1:0] w_ext;
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] prod;

    // The activation gets a zero sign bit so the multiply stays signed*signed.
    assign w_ext = PROD_W'($signed(weight));
    assign a_ext = $signed(PROD_W'({1'b0, act}));
    assign prod  = w_ext * a_ext;

    assign acc_out = acc_in + ACC_WIDTH'(sext(SEXT_MAX'(prod), 6'(PROD_W)));

endmodule

// File: rtl/neuron_mac.sv
// Single neuron: pops N_INPUTS weight chunks from the FIFO, accumulates them
// against latched activations on top of a bias, and presents the (optionally ReLU'd) sum.
module neuron_mac
    import nn_pkg::*;
#(
    parameter int W_WIDTH   = W_WIDTH_DEF,
    parameter int A_WIDTH   = A_WIDTH_DEF,
    parameter int N_INPUTS  = 8,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter bit RELU_EN   = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [A_WIDTH*N_INPUTS-1:0]   act_in,
    input  logic [ACC_WIDTH-1:0]          bias,
    input  logic [W_WIDTH-1:0]            fifo_dout,
    input  logic                          fifo_empty,
    output logic                          fifo_rd_en,
    output logic [ACC_WIDTH-1:0]          result,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic                          busy
);

    localparam int CNT_W = $clog2(N_INPUTS + 1);
    localparam int IDX_W = $clog2(N_INPUTS);
    localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N_INPUTS);
    localparam logic [CNT_W-1:0] LAST_USE = CNT_W'(N_INPUTS - 1);

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     issue_cnt;
    logic [CNT_W-1:0]     use_cnt;
    logic                 rd_pend;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_next;
    logic [A_WIDTH-1:0]   act_q [N_INPUTS];
    logic [A_WIDTH-1:0]   act_cur;
    logic                 last_mac;

    // use_cnt only indexes while a chunk is pending, so it is always below N_INPUTS here.
    assign act_cur  = act_q[use_cnt[IDX_W-1:0]];
    assign last_mac = rd_pend && (use_cnt == LAST_USE);
    assign busy     = (state != IDLE);

    mac_unit #(
        .W_WIDTH  (W_WIDTH),
        .A_WIDTH  (A_WIDTH),
        .ACC_WIDTH(ACC_WIDTH)
    ) u_mac (
        .acc_in (acc),
        .weight (fifo_dout),
        .act    (act_cur),
        .acc_out(acc_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        fifo_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                fifo_rd_en = !fifo_empty && (issue_cnt < N_CNT);
                if (last_mac) state_next = OUT;
            end
            OUT: begin
                if (result_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt    <= '0;
            use_cnt      <= '0;
            rd_pend      <= 1'b0;
            acc          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= bias;
                        issue_cnt <= '0;
                        use_cnt   <= '0;
                        rd_pend   <= 1'b0;
                    end
                end
                RUN: begin
                    rd_pend <= fifo_rd_en;
                    if (fifo_rd_en) issue_cnt <= issue_cnt + CNT_W'(1);
                    if (rd_pend) begin
                        acc     <= acc_next;
                        use_cnt <= use_cnt + CNT_W'(1);
                    end
                    if (last_mac) begin
                        result       <= (RELU_EN && acc_next[ACC_WIDTH-1]) ? '0 : acc_next;
                        result_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (result_ready) result_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the activation bank has no reset; it is always written on start
    // before any MAC reads it, so reset would only add fan-out.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                act_q[i] <= act_in[i*A_WIDTH +: A_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac with a behavioural weight FIFO; a second
// instance with ReLU disabled shares all stimulus to check raw signed sums.
module tb_neuron_mac;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] act_in;
    logic [15:0] bias;
    logic [3:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] result;
    logic        result_valid;
    logic        result_ready;
    logic        busy;
    logic        raw_rd_en;
    logic [15:0] raw_result;
    logic        raw_valid;
    logic        raw_busy;

    logic [3:0] wmem [256];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         pop_cnt = 0;
    int         viol_cnt = 0;
    logic       fifo_flush = 1'b0;
    logic       force_empty = 1'b0;
    logic       toggle_en = 1'b0;

    int checks = 0;
    int failures = 0;

    neuron_mac #(.RELU_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .act_in(act_in), .bias(bias),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .result(result), .result_valid(result_valid), .result_ready(result_ready),
        .busy(busy)
    );

    neuron_mac #(.RELU_EN(1'b0)) dut_raw (
        .clk(clk), .rst(rst), .start(start), .act_in(act_in), .bias(bias),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(raw_rd_en),
        .result(raw_result), .result_valid(raw_valid), .result_ready(result_ready),
        .busy(raw_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: data appears the cycle after an accepted pop.
    assign fifo_empty = force_empty || (wr_ptr == rd_ptr);

    initial fifo_dout = 4'h0;
    always @(posedge clk) begin
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en) begin
            fifo_dout <= wmem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
            pop_cnt   <= pop_cnt + 1;
        end
    end

    always @(posedge clk) force_empty <= toggle_en ? ~force_empty : 1'b0;

    always @(negedge clk) begin
        if (fifo_rd_en && fifo_empty) viol_cnt <= viol_cnt + 1;
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            wmem[wr_ptr[7:0]] = w;
            wr_ptr++;
        end
    endtask

    task automatic set_act_all(input int v);
        for (int i = 0; i < 8; i++) act_in[i*8 +: 8] = 8'(v);
    endtask

    task automatic set_act_ramp();
        for (int i = 0; i < 8; i++) act_in[i*8 +: 8] = 8'(i + 1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cycles);
        cycles = 0;
        while (!result_valid && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        if (!result_valid) check("valid_timeout", 32'(result_valid), 1);
    endtask

    task automatic accept();
        @(negedge clk);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int p0;
        int v0;
        int bad;
        int n;

        rst          = 1'b1;
        start        = 1'b0;
        act_in       = '0;
        bias         = '0;
        result_ready = 1'b0;

        // Reset state
        #12;
        check("rst_result", 32'($signed(result)), 0);
        check("rst_valid", 32'(result_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rd_en", 32'(fifo_rd_en), 0);
        check("rst_raw_rd_en", 32'(raw_rd_en), 0);
        check("rst_raw_busy", 32'(raw_busy), 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: weights +1, act 1..8, bias 0 -> 36 after 9 cycles, 8 pops
        push(4'h1, 8);
        set_act_ramp();
        bias = 16'd0;
        p0 = pop_cnt;
        pulse_start();
        wait_valid(40, lat);
        check("t1_latency", lat, 9);
        check("t1_result", 32'($signed(result)), 36);
        check("t1_raw_result", 32'($signed(raw_result)), 36);
        check("t1_pops", pop_cnt - p0, 8);
        check("t1_busy_out", 32'(busy), 1);
        accept();
        check("t1_valid_clr", 32'(result_valid), 0);
        check("t1_busy_clr", 32'(busy), 0);

        // 2: weights -8, act 255 -> ReLU 0, raw -16320
        push(4'h8, 8);
        set_act_all(255);
        bias = 16'd0;
        pulse_start();
        wait_valid(40, lat);
        check("t2_relu_result", 32'($signed(result)), 0);
        check("t2_raw_valid", 32'(raw_valid), 1);
        check("t2_raw_result", 32'($signed(raw_result)), -16320);
        accept();

        // 3: fifo_empty toggling, weights +2, act 3, bias 5 -> 53
        toggle_en = 1'b1;
        push(4'h2, 8);
        set_act_all(3);
        bias = 16'd5;
        p0 = pop_cnt;
        v0 = viol_cnt;
        pulse_start();
        wait_valid(60, lat);
        check("t3_result", 32'($signed(result)), 53);
        check("t3_pops", pop_cnt - p0, 8);
        check("t3_rd_while_empty", viol_cnt - v0, 0);
        toggle_en = 1'b0;
        accept();

        // 4: hold result 10 cycles with ready low; start pulses ignored
        push(4'h1, 8);
        set_act_all(4);
        bias = 16'd7;
        pulse_start();
        wait_valid(40, lat);
        check("t4_result", 32'($signed(result)), 39);
        push(4'h3, 8);
        p0  = pop_cnt;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            start = (c == 3 || c == 6);
            bias  = 16'h1234;
            set_act_all(c + 20);
            @(negedge clk);
            if ($signed(result) !== 16'sd39 || result_valid !== 1'b1 || busy !== 1'b1) bad++;
        end
        start = 1'b0;
        check("t4_hold_stable", bad, 0);
        check("t4_no_pops_in_out", pop_cnt - p0, 0);
        accept();
        check("t4_valid_clr", 32'(result_valid), 0);
        check("t4_busy_clr", 32'(busy), 0);

        // 5: async reset after 3 pops, then fresh neuron
        @(negedge clk);
        fifo_flush = 1'b1;
        @(negedge clk);
        fifo_flush = 1'b0;
        push(4'h3, 8);
        set_act_ramp();
        bias = 16'd0;
        p0 = pop_cnt;
        pulse_start();
        n = 0;
        while ((pop_cnt - p0) < 3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t5_reached_3_pops", pop_cnt - p0, 3);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_result", 32'($signed(result)), 0);
        check("t5_rst_valid", 32'(result_valid), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_rd_en", 32'(fifo_rd_en), 0);
        @(negedge clk);
        rst = 1'b0;
        fifo_flush = 1'b1;
        @(negedge clk);
        fifo_flush = 1'b0;
        push(4'hF, 8);
        set_act_ramp();
        bias = 16'd100;
        p0 = pop_cnt;
        pulse_start();
        wait_valid(40, lat);
        check("t5_result", 32'($signed(result)), 64);
        check("t5_pops", pop_cnt - p0, 8);
        accept();

        // 6: two neurons back-to-back, second starts the cycle after acceptance
        push(4'hF, 8);
        for (int i = 0; i < 4; i++) begin
            push(4'h7, 1);
            push(4'hD, 1);
        end
        set_act_all(10);
        bias = 16'd100;
        p0 = pop_cnt;
        pulse_start();
        wait_valid(40, lat);
        check("t6a_result", 32'($signed(result)), 20);
        @(negedge clk);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        start = 1'b1;
        set_act_ramp();
        bias = 16'd0;
        check("t6_idle_between", 32'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        wait_valid(40, lat);
        check("t6b_latency", lat, 9);
        check("t6b_result", 32'($signed(result)), 52);
        check("t6b_raw_result", 32'($signed(raw_result)), 52);
        check("t6_pops", pop_cnt - p0, 16);
        accept();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
